// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the shared-bus protocol. This package is reused by the
// BusController, the bus masters and bus_mem_slave.
//   - bus_cmd_e      : command codes carried in ctrl[2:0]
//   - CTRL_* params  : bit positions of the ctrl fields (cmd, beats-1)
//   - slave_state_e  : state encoding of the memory slave FSM
//   - make_ctrl()    : packs a command and a beats-remaining-1 field into ctrl[7:0]
// ---------------------------------------------------------------------------
package bus_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE  = 3'd0,
        CMD_RD    = 3'd1,
        CMD_WR    = 3'd2,
        CMD_RDATA = 3'd3,
        CMD_WACK  = 3'd4,
        CMD_ERR   = 3'd5,
        CMD_WDATA = 3'd6
    } bus_cmd_e;

    localparam int unsigned CTRL_CMD_LSB   = 0;
    localparam int unsigned CTRL_CMD_W     = 3;
    localparam int unsigned CTRL_BEATS_LSB = 4;
    localparam int unsigned CTRL_BEATS_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_DATA = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_REQ  = 3'd4,
        ST_RD_DATA = 3'd5
    } slave_state_e;

    // Build the low byte of a ctrl word: beats field in [7:4], bit 3 reserved, cmd in [2:0].
    function automatic logic [7:0] make_ctrl(input bus_cmd_e cmd, input logic [3:0] beats);
        return {beats, 1'b0, cmd};
    endfunction

endpackage

// File: rtl/bus_mem_array.sv
// ---------------------------------------------------------------------------
// bus_mem_array
// Word storage behind bus_mem_slave: one synchronous write port and one
// asynchronous read port. The contents are deliberately not reset, so data
// survives a reset of the slave FSM.
// Ports:
//   clk   in   write clock
//   we    in   write enable (sampled on rising clk)
//   waddr in   write word address
//   wdata in   write data
//   raddr in   read word address
//   rdata out  read data (combinational)
// ---------------------------------------------------------------------------
module bus_mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/bus_mem_slave.sv
// ---------------------------------------------------------------------------
// bus_mem_slave
// Memory slave on the shared bus. It accepts RD/WR bursts of 1..16 beats
// addressed to its window [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS). It answers
// writes with a WACK and reads with RDATA beats, and it drives the bus only
// after ack is granted. All outputs are registered, so a beat or response
// appears in the cycle after the edge at which ack was sampled.
// Optional feature: define BUS_SLAVE_ERR_EN to reject bursts that run past
// the last word. Such a burst gets one ERR cycle and no memory access.
// Without BUS_SLAVE_ERR_EN, the burst address wraps modulo DEPTH_WORDS.
// Ports:
//   clk      in   single clock, rising edge
//   reset    in   asynchronous active-high reset
//   bus_in   in   address (with RD/WR) or write data (with WDATA)
//   ctrl_in  in   command [2:0], beats-1 [7:4]
//   req      out  request to drive the bus
//   ack      in   grant from the BusController
//   bus_out  out  read data beat, 0 when idle
//   ctrl_out out  response command/beats-remaining-1, 0 when idle
// ---------------------------------------------------------------------------
module bus_mem_slave
    import bus_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = 32,
    parameter int unsigned CTRL_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BUS_WIDTH-1:0]  bus_in,
    input  logic [CTRL_WIDTH-1:0] ctrl_in,
    output logic                  req,
    input  logic                  ack,
    output logic [BUS_WIDTH-1:0]  bus_out,
    output logic [CTRL_WIDTH-1:0] ctrl_out
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [63:0] ADDR_LO   = 64'(BASE_ADDR);
    localparam logic [63:0] SPAN      = 64'(DEPTH_WORDS) << 2;
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES - 1);
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    slave_state_e          state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [3:0]            cnt_q, cnt_d;      // beats remaining - 1
    logic [2:0]            wait_q, wait_d;
    logic                  err_q, err_d;
    logic                  req_q, req_d;
    logic [BUS_WIDTH-1:0]  bus_out_q, bus_out_d;
    logic [CTRL_WIDTH-1:0] ctrl_out_q, ctrl_out_d;

    bus_cmd_e              cmd_s;
    logic [3:0]            beats_s;
    logic [63:0]           offset_s;
    logic                  in_range_s;
    logic [AW-1:0]         word_s;
    logic                  overrun_s;
    logic                  mem_we_s;
    logic [BUS_WIDTH-1:0]  mem_rdata_s;
    logic                  ctrl_unused_s;

    assign cmd_s   = bus_cmd_e'(ctrl_in[CTRL_CMD_LSB +: CTRL_CMD_W]);
    assign beats_s = ctrl_in[CTRL_BEATS_LSB +: CTRL_BEATS_W];

    // Modular subtraction: addresses below BASE_ADDR wrap to huge offsets and
    // fail the single range compare.
    assign offset_s   = 64'(bus_in) - ADDR_LO;
    assign in_range_s = (offset_s < SPAN);
    assign word_s     = offset_s[AW+1:2];
    assign ctrl_unused_s = ^{ctrl_in, offset_s};

`ifdef BUS_SLAVE_ERR_EN
    localparam int unsigned EW = AW + 5;
    logic [EW-1:0] end_s;
    assign end_s     = EW'(word_s) + EW'(beats_s) + EW'(1'b1);
    assign overrun_s = (end_s > EW'(DEPTH_WORDS));
`else
    assign overrun_s = 1'b0;
`endif

    bus_mem_array #(
        .DATA_W (BUS_WIDTH),
        .DEPTH  (DEPTH_WORDS)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (addr_q),
        .wdata (bus_in),
        .raddr (addr_q),
        .rdata (mem_rdata_s)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= {AW{1'b0}};
            cnt_q      <= 4'd0;
            wait_q     <= 3'd0;
            err_q      <= 1'b0;
            req_q      <= 1'b0;
            bus_out_q  <= {BUS_WIDTH{1'b0}};
            ctrl_out_q <= {CTRL_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            req_q      <= req_d;
            bus_out_q  <= bus_out_d;
            ctrl_out_q <= ctrl_out_d;
        end
    end

    // Next-state, burst counters and memory write enable.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        err_d    = err_q;
        mem_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (((cmd_s == CMD_RD) || (cmd_s == CMD_WR)) && in_range_s) begin
                    addr_d = word_s;
                    cnt_d  = beats_s;
                    err_d  = overrun_s;
                    wait_d = WAIT_INIT;
                    if (cmd_s == CMD_WR) begin
                        state_d = ST_WR_DATA;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_RD_REQ;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (cmd_s == CMD_WDATA) begin
                    // An overrun burst still consumes its beats but never writes.
                    mem_we_s = ~err_q;
                    addr_d   = addr_q + ADDR_ONE;
                    if (cnt_q == 4'd0) begin
                        state_d = ST_WR_RESP;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_RESP: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_RD_WAIT: begin
                if (wait_q == 3'd0) begin
                    state_d = ST_RD_REQ;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            ST_RD_REQ: begin
                if (ack) begin
                    state_d = ST_RD_DATA;
                end else begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_DATA: begin
                if (ack) begin
                    addr_d = addr_q + ADDR_ONE;
                    if (err_q || (cnt_q == 4'd0)) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end else begin
                    state_d = ST_RD_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs: req follows the next state, and a beat/response is
    // presented for one cycle after each ack edge. req stays high for that cycle.
    always_comb begin
        req_d      = (state_d == ST_WR_RESP) || (state_d == ST_RD_REQ) ||
                     (state_d == ST_RD_DATA);
        bus_out_d  = {BUS_WIDTH{1'b0}};
        ctrl_out_d = {CTRL_WIDTH{1'b0}};
        case (state_q)
            ST_WR_RESP: begin
                if (ack) begin
                    req_d = 1'b1;
                    ctrl_out_d[7:0] = make_ctrl(err_q ? CMD_ERR : CMD_WACK, 4'd0);
                end else begin
                    ctrl_out_d = {CTRL_WIDTH{1'b0}};
                end
            end
            ST_RD_DATA: begin
                if (ack) begin
                    req_d = 1'b1;
                    if (err_q) begin
                        ctrl_out_d[7:0] = make_ctrl(CMD_ERR, 4'd0);
                    end else begin
                        bus_out_d       = mem_rdata_s;
                        ctrl_out_d[7:0] = make_ctrl(CMD_RDATA, cnt_q);
                    end
                end else begin
                    ctrl_out_d = {CTRL_WIDTH{1'b0}};
                end
            end
            default: begin
                ctrl_out_d = {CTRL_WIDTH{1'b0}};
            end
        endcase
    end

    assign req      = req_q;
    assign bus_out  = bus_out_q;
    assign ctrl_out = ctrl_out_q;

endmodule

// File: tb/tb_bus_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_bus_mem_slave
// Directed bench for bus_mem_slave with default parameters (32-bit bus,
// 256 words, base 0, one wait state). The bench keeps a shadow copy of the
// memory from the data it writes. Burst-overrun expectations follow
// BUS_SLAVE_ERR_EN.
// ---------------------------------------------------------------------------
module tb_bus_mem_slave;

`ifdef BUS_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bus_in;
    logic [7:0]  ctrl_in;
    logic        req;
    logic        ack;
    logic [31:0] bus_out;
    logic [7:0]  ctrl_out;

    logic [31:0] model [256];
    int          n_checks = 0;
    int          n_errors = 0;

    bus_mem_slave dut (
        .clk      (clk),
        .reset    (reset),
        .bus_in   (bus_in),
        .ctrl_in  (ctrl_in),
        .req      (req),
        .ack      (ack),
        .bus_out  (bus_out),
        .ctrl_out (ctrl_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // One clock; outputs are looked at 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [31:0] addr, input int n, input logic [31:0] d0,
                            input bit stall);
        int w;
        bit err;
        w   = int'(addr >> 2);
        err = ERR_EN && ((w + n) > 256);
        bus_in  = addr;
        ctrl_in = {4'(n - 1), 4'h2};
        step();
        check_val("wr_accept_req", req, 64'h0);
        for (int i = 0; i < n; i++) begin
            if (stall && (i == 1)) begin
                ctrl_in = 8'h00;
                bus_in  = 32'hBAD0_BAD0;
                step();
                check_val("wr_stall_req", req, 64'h0);
            end
            ctrl_in = 8'h06;
            bus_in  = d0 + 32'(i);
            step();
        end
        ctrl_in = 8'h00;
        bus_in  = 32'h0;
        check_val("wr_resp_req", req, 64'h1);
        check_val("wr_resp_ctrl_idle", ctrl_out, 64'h0);
        step();
        check_val("wr_wait_ack_req", req, 64'h1);
        check_val("wr_wait_ack_ctrl", ctrl_out, 64'h0);
        ack = 1'b1;
        step();
        check_val("wr_resp_ctrl", ctrl_out, err ? 64'h05 : 64'h04);
        check_val("wr_resp_req_hold", req, 64'h1);
        ack = 1'b0;
        step();
        check_val("wr_done_req", req, 64'h0);
        check_val("wr_done_ctrl", ctrl_out, 64'h0);
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                model[(w + i) % 256] = d0 + 32'(i);
            end
        end
    endtask

    task automatic rd_burst(input logic [31:0] addr, input int n, input int pause_at);
        int w;
        bit err;
        w   = int'(addr >> 2);
        err = ERR_EN && ((w + n) > 256);
        bus_in  = addr;
        ctrl_in = {4'(n - 1), 4'h1};
        ack     = 1'b0;
        step();
        bus_in  = 32'h0;
        ctrl_in = 8'h00;
        check_val("rd_wait_req", req, 64'h0);
        step();
        check_val("rd_req_rise", req, 64'h1);
        ack = 1'b1;
        step();
        check_val("rd_grant_ctrl", ctrl_out, 64'h0);
        if (err) begin
            step();
            check_val("rd_err_ctrl", ctrl_out, 64'h05);
            check_val("rd_err_bus", bus_out, 64'h0);
            check_val("rd_err_req", req, 64'h1);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (i == pause_at) begin
                    // Pause the burst and offer a new RD, which must be ignored.
                    ack     = 1'b0;
                    bus_in  = 32'h0000_0020;
                    ctrl_in = 8'h31;
                    for (int p = 0; p < 3; p++) begin
                        step();
                        bus_in  = 32'h0;
                        ctrl_in = 8'h00;
                        check_val("rd_pause_req", req, 64'h1);
                        check_val("rd_pause_ctrl", ctrl_out, 64'h0);
                    end
                    ack = 1'b1;
                end
                step();
                check_val("rd_beat_data", bus_out, 64'(model[(w + i) % 256]));
                check_val("rd_beat_ctrl", ctrl_out, 64'({4'(n - 1 - i), 4'h3}));
                check_val("rd_beat_req", req, 64'h1);
            end
        end
        ack = 1'b0;
        step();
        check_val("rd_done_req", req, 64'h0);
        check_val("rd_done_ctrl", ctrl_out, 64'h0);
        check_val("rd_done_bus", bus_out, 64'h0);
        step();
        check_val("rd_idle_req", req, 64'h0);
    endtask

    initial begin
        reset   = 1'b1;
        bus_in  = 32'h0;
        ctrl_in = 8'h00;
        ack     = 1'b0;
        for (int i = 0; i < 256; i++) begin
            model[i] = 32'h0;
        end
        step();
        step();
        check_val("rst_req", req, 64'h0);
        check_val("rst_bus", bus_out, 64'h0);
        check_val("rst_ctrl", ctrl_out, 64'h0);
        reset = 1'b0;
        step();
        check_val("idle_req", req, 64'h0);

        // Single-beat write, then a 3-beat write with a stall cycle.
        wr_burst(32'h0000_0010, 1, 32'hDEAD_BEEF, 1'b0);
        wr_burst(32'h0000_0014, 3, 32'h1111_0000, 1'b1);

        // 4-beat reads: ack held high, then with a 3-cycle ack pause after beat 2.
        rd_burst(32'h0000_0010, 4, -1);
        rd_burst(32'h0000_0010, 4, 2);

        // Out-of-window commands are ignored.
        bus_in  = 32'h0000_0400;
        ctrl_in = 8'h01;
        step();
        bus_in  = 32'h0;
        ctrl_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("oor_rd_req", req, 64'h0);
            check_val("oor_rd_ctrl", ctrl_out, 64'h0);
            check_val("oor_rd_bus", bus_out, 64'h0);
        end
        bus_in  = 32'hFFFF_FFFC;
        ctrl_in = 8'h02;
        step();
        bus_in  = 32'h1234_5678;
        ctrl_in = 8'h06;
        step();
        bus_in  = 32'h0;
        ctrl_in = 8'h00;
        step();
        check_val("oor_wr_req", req, 64'h0);

        // Address wrap (or overrun error with BUS_SLAVE_ERR_EN).
        wr_burst(32'h0000_03F8, 2, 32'hA0A0_0000, 1'b0);
        wr_burst(32'h0000_0000, 2, 32'hA0A0_0002, 1'b0);
        rd_burst(32'h0000_03F8, 4, -1);
        wr_burst(32'h0000_03FC, 2, 32'hB0B0_0000, 1'b0);
        rd_burst(32'h0000_03FC, 1, -1);
        rd_burst(32'h0000_0000, 1, -1);

        // Asynchronous reset while a read beat is on the bus.
        bus_in  = 32'h0000_0010;
        ctrl_in = 8'h31;
        step();
        bus_in  = 32'h0;
        ctrl_in = 8'h00;
        step();
        ack = 1'b1;
        step();
        step();
        check_val("arst_pre_beat", bus_out, 64'(model[4]));
        #1;
        reset = 1'b1;
        #1;
        check_val("arst_req", req, 64'h0);
        check_val("arst_bus", bus_out, 64'h0);
        check_val("arst_ctrl", ctrl_out, 64'h0);
        ack = 1'b0;
        step();
        reset = 1'b0;
        step();
        check_val("arst_after_req", req, 64'h0);

        // Reset during beat 2 of a 4-beat write: only beat 1 lands.
        wr_burst(32'h0000_0044, 1, 32'h5555_5555, 1'b0);
        bus_in  = 32'h0000_0040;
        ctrl_in = 8'h32;
        step();
        ctrl_in = 8'h06;
        bus_in  = 32'hC0C0_0000;
        step();
        model[16] = 32'hC0C0_0000;
        bus_in    = 32'hC0C0_0001;
        #2;
        reset = 1'b1;
        #1;
        check_val("wrst_req", req, 64'h0);
        check_val("wrst_ctrl", ctrl_out, 64'h0);
        step();
        ctrl_in = 8'h00;
        bus_in  = 32'h0;
        reset   = 1'b0;
        step();
        check_val("wrst_after_req", req, 64'h0);
        rd_burst(32'h0000_0040, 2, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
